// File: rtl/mmio_reg_bridge.sv
// ---------------------------------------------------------------------------
// mmio_reg_bridge
//   Bridges the 5-channel MMIO slave interface (ar/r/aw/w/b) driven by
//   Cosim_MMIO onto a single-outstanding req/ack register bus. It arbitrates
//   between reads and writes and decodes the address. It also aborts
//   register accesses that are never acknowledged. Responses use AXI-style
//   codes: 0 OKAY, 2 SLVERR, 3 DECERR.
//
// Parameters
//   NUM_REGS  number of 64-bit-stride register slots (idx = addr >> 3)
//   IDX_W     width of reg_idx, >= clog2(NUM_REGS)
//   TIMEOUT   cycles reg_req may stay high without reg_ack (>= 1)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   arvalid/arready/araddr    read address channel
//   rvalid/rready/rdata/rresp read data channel
//   awvalid/awready/awaddr    write address channel
//   wvalid/wready/wdata       write data channel
//   bvalid/bready/bresp       write response channel
//   reg_req/reg_we/reg_idx/reg_wdata  register request (held until ack/abort)
//   reg_ack/reg_rdata/reg_err         register completion
// ---------------------------------------------------------------------------
module mmio_reg_bridge #(
  parameter int unsigned NUM_REGS = 1024,
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arvalid,
  output logic             arready,
  input  logic [31:0]      araddr,
  output logic             rvalid,
  input  logic             rready,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      awaddr,
  input  logic             wvalid,
  output logic             wready,
  input  logic [31:0]      wdata,
  output logic             bvalid,
  input  logic             bready,
  output logic [1:0]       bresp,
  output logic             reg_req,
  output logic             reg_we,
  output logic [IDX_W-1:0] reg_idx,
  output logic [31:0]      reg_wdata,
  input  logic             reg_ack,
  input  logic [31:0]      reg_rdata,
  input  logic             reg_err
);

  localparam int unsigned     TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
  localparam logic [28:0]     NREG  = 29'(NUM_REGS);
  localparam logic [1:0]      RESP_OKAY   = 2'd0;
  localparam logic [1:0]      RESP_SLVERR = 2'd2;
  localparam logic [1:0]      RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        state, state_nxt;
  logic          last_wr;   // type served last; 1 = write
  logic          cur_we;    // type of the transaction in flight
  logic [TW-1:0] tcnt;      // reg_req cycles seen so far, minus one

  logic          rd_cand, wr_cand;
  logic          grant_rd, grant_wr;
  logic [31:0]   gaddr;
  logic [28:0]   gidx;
  logic          decerr;

  // Next state, grant pulses and capture-time decode.
  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    rd_cand   = arvalid;
    wr_cand   = awvalid && wvalid;

    // Ready is gated by rst so nothing can look accepted while reset is held.
    if (state == IDLE && !rst) begin
      grant_rd = rd_cand && (!wr_cand || last_wr);
      grant_wr = wr_cand && (!rd_cand || !last_wr);
    end
    arready = grant_rd;
    awready = grant_wr;
    wready  = grant_wr;

    gaddr  = grant_wr ? awaddr : araddr;
    gidx   = gaddr[31:3];
    decerr = (gaddr[2:0] != '0) || (gidx >= NREG) || (grant_wr && gidx == '0);

    case (state)
      IDLE: if (grant_rd || grant_wr) state_nxt = decerr ? RESP : BUS;
      BUS:  if (reg_ack || tcnt == TLAST) state_nxt = RESP;
      RESP: if (cur_we ? bready : rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: capture, bus request, response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr   <= 1'b1;
      cur_we    <= 1'b0;
      tcnt      <= '0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_idx   <= '0;
      reg_wdata <= '0;
      rvalid    <= 1'b0;
      bvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= '0;
      bresp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            cur_we  <= grant_wr;
            last_wr <= grant_wr;
            reg_we  <= grant_wr;
            reg_idx <= gidx[IDX_W-1:0];
            tcnt    <= '0;
            if (grant_wr) reg_wdata <= wdata;
            if (decerr) begin
              if (grant_wr) begin
                bvalid <= 1'b1;
                bresp  <= RESP_DECERR;
              end else begin
                rvalid <= 1'b1;
                rresp  <= RESP_DECERR;
                rdata  <= '0;
              end
            end else begin
              reg_req <= 1'b1;
            end
          end
        end
        BUS: begin
          // An ack in the expiry cycle is checked first, so it wins.
          if (reg_ack) begin
            reg_req <= 1'b0;
            if (cur_we) begin
              bvalid <= 1'b1;
              bresp  <= reg_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
              rvalid <= 1'b1;
              rresp  <= reg_err ? RESP_SLVERR : RESP_OKAY;
              rdata  <= reg_err ? '0 : reg_rdata;
            end
          end else if (tcnt == TLAST) begin
            reg_req <= 1'b0;
            if (cur_we) begin
              bvalid <= 1'b1;
              bresp  <= RESP_SLVERR;
            end else begin
              rvalid <= 1'b1;
              rresp  <= RESP_SLVERR;
              rdata  <= '0;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          if (cur_we && bready)  bvalid <= 1'b0;
          if (!cur_we && rready) rvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_reg_bridge.sv
module tb_mmio_reg_bridge;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        reg_req, reg_we;
  logic [9:0]  reg_idx;
  logic [31:0] reg_wdata;
  logic        reg_ack = 1'b0;
  logic [31:0] reg_rdata = '0;
  logic        reg_err = 1'b0;

  mmio_reg_bridge #(.NUM_REGS(1024), .IDX_W(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .reg_req(reg_req), .reg_we(reg_we), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register-file slave: acks on req cycle slv_wait+1, junk on reg_ack outside requests.
  int unsigned slv_wait = 0;
  bit          slv_never = 1'b0;
  bit          slv_err = 1'b0;
  int unsigned req_cyc = 0;
  int unsigned req_total = 0;
  int unsigned unstable_cnt = 0;
  logic        obs_we = 1'b0;
  logic [9:0]  obs_idx = '0;
  logic [31:0] obs_wdata = '0;
  bit [31:0]   smem [1024];
  bit [31:0]   ref_mem [1024];

  always @(negedge clk) begin
    if (reg_req) begin
      req_cyc   <= req_cyc + 1;
      req_total <= req_total + 1;
      if (req_cyc == 0) begin
        obs_we    <= reg_we;
        obs_idx   <= reg_idx;
        obs_wdata <= reg_wdata;
      end else if (reg_we !== obs_we || reg_idx !== obs_idx || reg_wdata !== obs_wdata) begin
        unstable_cnt <= unstable_cnt + 1;
      end
      if (!slv_never && req_cyc == slv_wait) begin
        reg_ack   <= 1'b1;
        reg_err   <= slv_err;
        reg_rdata <= slv_err ? $urandom : smem[reg_idx];
        if (reg_we && !slv_err) smem[reg_idx] <= reg_wdata;
      end else begin
        reg_ack   <= 1'b0;
        reg_err   <= 1'($urandom);
        reg_rdata <= $urandom;
      end
    end else begin
      req_cyc   <= 0;
      reg_ack   <= ($urandom_range(0, 3) == 0);
      reg_err   <= 1'($urandom);
      reg_rdata <= $urandom;
    end
  end

  // One complete transaction, checked against rules computed from the address,
  // slave behaviour and the reference register array. Starts and ends on a negedge.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int unsigned wait_c, input bit never, input bit err,
                        input int unsigned hold, input string tag);
    logic [28:0] idx29;
    bit          dec, tmo, granted, seen;
    int unsigned exp_lat, exp_req, lat, start_req, start_unst;
    logic [1:0]  exp_resp, keep_resp;
    logic [31:0] exp_rdata, keep_data;
    idx29     = addr[31:3];
    dec       = (addr[2:0] != 3'd0) || (idx29 >= 29'd1024) || (wr && idx29 == 29'd0);
    tmo       = !dec && (never || (wait_c + 1 > TIMEOUT));
    exp_lat   = dec ? 1 : (tmo ? TIMEOUT + 1 : wait_c + 2);
    exp_req   = dec ? 0 : (tmo ? TIMEOUT : wait_c + 1);
    exp_resp  = dec ? 2'd3 : ((tmo || err) ? 2'd2 : 2'd0);
    exp_rdata = (!wr && exp_resp == 2'd0) ? ref_mem[idx29[9:0]] : 32'd0;
    if (wr && exp_resp == 2'd0) ref_mem[idx29[9:0]] = data;
    slv_wait   = wait_c;
    slv_never  = never;
    slv_err    = err;
    start_req  = req_total;
    start_unst = unstable_cnt;
    if (wr) begin
      awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = addr; arvalid = 1'b1;
    end
    granted = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (wr ? (awready && wready && !arready) : (arready && !awready && !wready)) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ".grant"}, 32'(granted), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (!granted) return;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 60; k++) begin
      if (wr ? bvalid : rvalid) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ".lat"}, seen ? 32'(lat) : 32'hDEAD, 32'(exp_lat));
    if (!seen) return;
    chk({tag, ".resp"}, 32'(wr ? bresp : rresp), 32'(exp_resp));
    if (!wr) chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".othervalid"}, 32'(wr ? rvalid : bvalid), 32'd0);
    chk({tag, ".reqcyc"}, 32'(req_total - start_req), 32'(exp_req));
    if (exp_req > 0) begin
      chk({tag, ".idx"}, 32'(obs_idx), 32'(idx29[9:0]));
      chk({tag, ".we"}, 32'(obs_we), 32'(wr));
      if (wr) chk({tag, ".wdata"}, obs_wdata, data);
      chk({tag, ".stable"}, 32'(unstable_cnt - start_unst), 32'd0);
    end
    keep_resp = wr ? bresp : rresp;
    keep_data = rdata;
    for (int h = 0; h < int'(hold); h++) begin
      @(negedge clk);
      chk({tag, ".hold"}, 32'(wr ? bvalid : rvalid), 32'd1);
      chk({tag, ".holdresp"}, 32'(wr ? bresp : rresp), 32'(keep_resp));
      if (!wr) chk({tag, ".holddata"}, rdata, keep_data);
    end
    if (wr) bready = 1'b1; else rready = 1'b1;
    @(negedge clk);
    chk({tag, ".drop"}, 32'(wr ? bvalid : rvalid), 32'd0);
    bready = 1'b0;
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          got, gw, seen, wr_r;
    int unsigned sel, idx, low;
    logic [31:0] a;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset.valids", 32'({arready, awready, wready, rvalid, bvalid, reg_req, reg_we}), 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.resp", 32'({rresp, bresp}), 32'd0);
    chk("reset.regout", 32'(reg_idx) | reg_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write, held read, decode errors.
    do_txn(1'b1, 32'h18, 32'h11223344, 0, 1'b0, 1'b0, 0, "t1_wr");
    do_txn(1'b0, 32'h18, 32'h0, 5, 1'b0, 1'b0, 3, "t2_rd");
    do_txn(1'b1, 32'h0, 32'h55555555, 0, 1'b0, 1'b0, 0, "t3_wr0");
    do_txn(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b0, 0, "t3_rdmis");
    do_txn(1'b0, 32'h2000, 32'h0, 0, 1'b0, 1'b0, 1, "t3_rdoor");

    // Timeout and ack racing expiry.
    do_txn(1'b0, 32'h40, 32'h0, 0, 1'b1, 1'b0, 0, "t4_tmo");
    do_txn(1'b0, 32'h18, 32'h0, TIMEOUT - 1, 1'b0, 1'b0, 0, "t4_lastack");
    do_txn(1'b1, 32'h48, 32'hA5A5A5A5, 0, 1'b1, 1'b0, 0, "t4_wrtmo");
    do_txn(1'b1, 32'h50, 32'h5A5A5A5A, 2, 1'b0, 1'b1, 0, "t4_wrerr");

    // Contention from reset: R, W, R, W with a slave error on the second read.
    rst = 1'b1;
    araddr = 32'h28; awaddr = 32'h20; wdata = 32'hCAFE0004;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t5.rstready", 32'({arready, awready, wready}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      wr_r = (t % 2 == 1);
      slv_wait = t; slv_never = 1'b0; slv_err = (t == 2);
      got = 1'b0; gw = 1'b0;
      for (int k = 0; k < 50; k++) begin
        #1;
        if (arready || awready) begin
          got = 1'b1;
          gw  = awready;
          break;
        end
        @(negedge clk);
      end
      chk("t5.granttype", got ? 32'(gw) : 32'hDEAD, 32'(wr_r));
      if (wr_r) ref_mem[4] = 32'hCAFE0004;
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (rvalid || bvalid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t5.seen", 32'(seen), 32'd1);
      if (wr_r) begin
        chk("t5.bresp", 32'(bresp), 32'd0);
      end else begin
        chk("t5.rresp", 32'(rresp), (t == 2) ? 32'd2 : 32'd0);
        chk("t5.rdata", rdata, (t == 2) ? 32'd0 : ref_mem[5]);
      end
      if (t == 3) begin
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      end
      @(negedge clk);
    end
    rready = 1'b0; bready = 1'b0;
    @(negedge clk);

    // Reset while the bus request is pending.
    slv_never = 1'b1;
    araddr = 32'h30; arvalid = 1'b1;
    #1;
    chk("t6.grant", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6.reqbefore", 32'(reg_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6.reqdrop", 32'({reg_req, rvalid, bvalid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6.quiet", 32'({reg_req, rvalid, bvalid}), 32'd0);
    end
    do_txn(1'b0, 32'h18, 32'h0, 1, 1'b0, 1'b0, 0, "t6_rd");

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      idx = $urandom_range(1, 15);
      low = 0;
      case (sel)
        0: low = $urandom_range(1, 7);
        1: idx = 1024 + $urandom_range(0, 4095);
        2: idx = 0;
        default: ;
      endcase
      a = (32'(idx) << 3) | 32'(low);
      do_txn(1'($urandom), a, $urandom, $urandom_range(0, 9), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 5) == 0), $urandom_range(0, 3), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
